// File: rtl/mips_avalon_mem_slave_if.sv
// Avalon-MM bus bundle between a MIPS CPU port (master) and the memory model (slave).
interface mips_avalon_mem_slave_if #(
  parameter int unsigned DATA_WIDTH = 32
);
  logic [31:0]             address;
  logic                    read;
  logic                    write;
  logic [DATA_WIDTH-1:0]   writedata;
  logic [DATA_WIDTH/8-1:0] byteenable;
  logic                    waitrequest;
  logic [DATA_WIDTH-1:0]   readdata;
  logic [1:0]              response;

  modport master (
    output address, read, write, writedata, byteenable,
    input  waitrequest, readdata, response
  );

  modport slave (
    input  address, read, write, writedata, byteenable,
    output waitrequest, readdata, response
  );
endinterface

// File: rtl/mips_avalon_mem_slave.sv
// Avalon-MM memory slave: instruction ROM plus byte-writable data RAM, programmable wait states.
// Optional random extra wait cycles: define AVALON_SLAVE_RAND_WAIT_EN.
module mips_avalon_mem_slave #(
  parameter int unsigned DATA_WIDTH      = 32,
  parameter logic [31:0] INSTR_BASE      = 32'hBFC00000,
  parameter int unsigned INSTR_WORDS     = 1024,
  parameter logic [31:0] DATA_BASE       = 32'h00000000,
  parameter int unsigned DATA_WORDS      = 1024,
  parameter int unsigned READ_DELAY      = 2,
  parameter int unsigned WRITE_DELAY     = 2,
  parameter string       INSTR_INIT_FILE = "",
  parameter string       DATA_INIT_FILE  = ""
) (
  input  logic                          clk,
  input  logic                          rst_n,
  mips_avalon_mem_slave_if.slave        bus,
  output logic                          err_sticky,
  output logic [31:0]                   xfer_count
);

  localparam int unsigned BYTES = DATA_WIDTH / 8;
  localparam int unsigned OFFS  = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam int unsigned IW_I  = (INSTR_WORDS > 1) ? $clog2(INSTR_WORDS) : 1;
  localparam int unsigned IW_D  = (DATA_WORDS > 1) ? $clog2(DATA_WORDS) : 1;
  localparam int unsigned IW    = (IW_I > IW_D) ? IW_I : IW_D;
  localparam int unsigned CW    = 9;

  localparam logic [63:0] INSTR_SPAN = 64'(INSTR_WORDS) * 64'(BYTES);
  localparam logic [63:0] DATA_SPAN  = 64'(DATA_WORDS) * 64'(BYTES);

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_ACK  = 2'd2
  } state_t;

  typedef struct packed {
    logic                  is_wr;
    logic                  is_instr;
    logic [1:0]            resp;
    logic [IW-1:0]         word;
    logic [DATA_WIDTH-1:0] wdata;
    logic [BYTES-1:0]      be;
  } req_t;

  // Simulation-only storage; contents survive reset.
  logic [DATA_WIDTH-1:0] instr_mem [INSTR_WORDS];
  logic [DATA_WIDTH-1:0] data_mem  [DATA_WORDS];

  initial begin
    if ((DATA_WIDTH % 8) != 0 || DATA_WIDTH < 32 || DATA_WIDTH > 128)
      $fatal(1, "mips_avalon_mem_slave: DATA_WIDTH %0d unsupported", DATA_WIDTH);
    if (READ_DELAY < 1 || READ_DELAY > 255 || WRITE_DELAY < 1 || WRITE_DELAY > 255)
      $fatal(1, "mips_avalon_mem_slave: delays must be 1..255");
    if ((64'(INSTR_BASE) < 64'(DATA_BASE) + DATA_SPAN) &&
        (64'(DATA_BASE) < 64'(INSTR_BASE) + INSTR_SPAN))
      $fatal(1, "mips_avalon_mem_slave: instruction and data regions overlap");
    for (int i = 0; i < int'(INSTR_WORDS); i++) instr_mem[i] = '0;
    for (int i = 0; i < int'(DATA_WORDS); i++)  data_mem[i]  = '0;
  end

  state_t                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  req_t                  req_q, live_req, cur_req;
  logic                  req;
  logic                  ack_go;
  logic                  hit_i, hit_d;
  logic [31:0]           off_i, off_d;
  logic [CW-1:0]         base_delay, extra, delay;
  logic [DATA_WIDTH-1:0] rd_word;
  logic [DATA_WIDTH-1:0] readdata_q;
  logic [1:0]            response_q;

  assign req             = bus.read | bus.write;
  assign bus.waitrequest = req & (state_q != S_ACK);
  assign bus.readdata    = readdata_q;
  assign bus.response    = response_q;

  // Address decode on the live bus; result is latched with the request.
  assign off_i = bus.address - INSTR_BASE;
  assign off_d = bus.address - DATA_BASE;
  assign hit_i = (bus.address >= INSTR_BASE) && (64'(off_i) < INSTR_SPAN);
  assign hit_d = (bus.address >= DATA_BASE) && (64'(off_d) < DATA_SPAN);

  always_comb begin
    live_req          = '0;
    live_req.is_wr    = bus.write;
    live_req.is_instr = hit_i;
    live_req.wdata    = bus.writedata;
    live_req.be       = bus.byteenable;
    live_req.word     = hit_i ? IW'(off_i >> OFFS) : IW'(off_d >> OFFS);
    if (bus.read && bus.write)     live_req.resp = RESP_SLVERR;
    else if (!hit_i && !hit_d)     live_req.resp = RESP_DECERR;
    else if (hit_i && bus.write)   live_req.resp = RESP_SLVERR;
    else                           live_req.resp = RESP_OKAY;
  end

  // Error completions always take the read latency.
  assign base_delay = (live_req.is_wr && live_req.resp == RESP_OKAY) ? CW'(WRITE_DELAY)
                                                                     : CW'(READ_DELAY);
  assign delay      = base_delay + extra;

`ifdef AVALON_SLAVE_RAND_WAIT_EN
  logic [7:0] lfsr_q;

  // x^8+x^6+x^5+x^4+1, advanced once per completed transfer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                lfsr_q <= 8'hA5;
    else if (state_q == S_ACK) lfsr_q <= {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
  end

  assign extra = CW'(lfsr_q[1:0]);
`else
  assign extra = '0;
`endif

  // Transfer entering ACK straight from IDLE uses the live request, otherwise the latched one.
  assign cur_req = (state_q == S_IDLE) ? live_req : req_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ack_go  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req) begin
          if (delay == CW'(1)) begin
            state_d = S_ACK;
            ack_go  = 1'b1;
          end else begin
            state_d = S_WAIT;
            cnt_d   = delay - CW'(2);
          end
        end
      end
      S_WAIT: begin
        if (!req) begin
          state_d = S_IDLE;
        end else if (cnt_q == '0) begin
          state_d = S_ACK;
          ack_go  = 1'b1;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_ACK:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    rd_word = '0;
    if (cur_req.resp == RESP_OKAY && !cur_req.is_wr) begin
      if (cur_req.is_instr) rd_word = instr_mem[IW_I'(cur_req.word)];
      else                  rd_word = data_mem[IW_D'(cur_req.word)];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      req_q      <= '0;
      readdata_q <= '0;
      response_q <= RESP_OKAY;
      err_sticky <= 1'b0;
      xfer_count <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (state_q == S_IDLE && req) req_q <= live_req;
      if (ack_go) begin
        readdata_q <= rd_word;
        response_q <= cur_req.resp;
        xfer_count <= xfer_count + 32'd1;
        if (cur_req.resp != RESP_OKAY) err_sticky <= 1'b1;
      end
    end
  end

  // Byte-lane write, committed only on entry to ACK so aborts and resets discard it.
  always_ff @(posedge clk) begin
    if (rst_n && ack_go && cur_req.resp == RESP_OKAY && cur_req.is_wr && !cur_req.is_instr) begin
      for (int b = 0; b < int'(BYTES); b++) begin
        if (cur_req.be[b]) data_mem[IW_D'(cur_req.word)][8*b +: 8] <= cur_req.wdata[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_mips_avalon_mem_slave.sv
// Scoreboard bench for mips_avalon_mem_slave: two instances with different wait-state settings.
module tb_mips_avalon_mem_slave;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  mips_avalon_mem_slave_if #(.DATA_WIDTH(32)) bus_a ();
  mips_avalon_mem_slave_if #(.DATA_WIDTH(32)) bus_b ();

  logic        err_a, err_b;
  logic [31:0] xc_a, xc_b;

  mips_avalon_mem_slave #(.READ_DELAY(2), .WRITE_DELAY(2)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(bus_a), .err_sticky(err_a), .xfer_count(xc_a)
  );

  mips_avalon_mem_slave #(.READ_DELAY(1), .WRITE_DELAY(5)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(bus_b), .err_sticky(err_b), .xfer_count(xc_b)
  );

  typedef struct {
    string       tag;
    int          dly;
    logic [31:0] rdata;
    logic [1:0]  resp;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old_w;
    for (int i = 0; i < 4; i++) if (be[i]) r[8*i +: 8] = new_w[8*i +: 8];
    return r;
  endfunction

  task automatic drive(input int which, input logic rd, input logic wr, input logic [31:0] addr,
                       input logic [31:0] wd, input logic [3:0] be);
    if (which == 0) begin
      bus_a.read = rd; bus_a.write = wr; bus_a.address = addr;
      bus_a.writedata = wd; bus_a.byteenable = be;
    end else begin
      bus_b.read = rd; bus_b.write = wr; bus_b.address = addr;
      bus_b.writedata = wd; bus_b.byteenable = be;
    end
  endtask

  function automatic logic wreq(input int which);
    return (which == 0) ? bus_a.waitrequest : bus_b.waitrequest;
  endfunction

  function automatic logic [31:0] rdata_o(input int which);
    return (which == 0) ? bus_a.readdata : bus_b.readdata;
  endfunction

  function automatic logic [1:0] resp_o(input int which);
    return (which == 0) ? bus_a.response : bus_b.response;
  endfunction

  // One full Avalon transfer: push expectation, count stall cycles, compare at completion.
  task automatic xfer(input int which, input string tag, input logic rd, input logic wr,
                      input logic [31:0] addr, input logic [31:0] wd, input logic [3:0] be,
                      input int dly, input logic [31:0] exp_rd, input logic [1:0] exp_resp);
    exp_t e;
    int   w;
    bit   done;
    @(posedge clk); #1;
    drive(which, rd, wr, addr, wd, be);
    e.tag = tag; e.dly = dly; e.rdata = exp_rd; e.resp = exp_resp;
    sb.push_back(e);
    w = 0;
    done = 1'b0;
    for (int c = 0; c < 400 && !done; c++) begin
      @(negedge clk);
      if (wreq(which)) begin
        w++;
      end else begin
        done = 1'b1;
        e = sb.pop_front();
`ifdef AVALON_SLAVE_RAND_WAIT_EN
        check_eq({e.tag, "_wait"}, 64'(w >= e.dly && w <= e.dly + 3), 64'd1);
`else
        check_eq({e.tag, "_wait"}, 64'(w), 64'(e.dly));
`endif
        check_eq({e.tag, "_rdata"}, 64'(rdata_o(which)), 64'(e.rdata));
        check_eq({e.tag, "_resp"}, 64'(resp_o(which)), 64'(e.resp));
      end
    end
    if (!done) begin
      e = sb.pop_front();
      check_eq({e.tag, "_timeout"}, 64'(w), 64'(e.dly));
    end
    @(posedge clk); #1;
    drive(which, 1'b0, 1'b0, addr, wd, be);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] w10, w20;
    rst_n = 1'b0;
    drive(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    drive(1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    #1;
    dut_a.instr_mem[0] = 32'h3C011234;
    dut_a.instr_mem[1] = 32'h0BADF00D;
    dut_a.data_mem[4]  = 32'h11223344;
    dut_a.data_mem[5]  = 32'h55667788;
    dut_b.data_mem[8]  = 32'hCAFEF00D;
    dut_b.data_mem[9]  = 32'hDEADBEEF;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_rdata", 64'(bus_a.readdata), 64'h0);
    check_eq("rst_resp", 64'(bus_a.response), 64'h0);
    check_eq("rst_err", 64'(err_a), 64'h0);
    check_eq("rst_count", 64'(xc_a), 64'h0);
    check_eq("rst_wait", 64'(bus_a.waitrequest), 64'h0);
    rst_n = 1'b1;

    // Instance A: READ_DELAY=2, WRITE_DELAY=2
    xfer(0, "a_rd_rom0", 1'b1, 1'b0, 32'hBFC00000, 32'h0, 4'hF, 2, 32'h3C011234, 2'b00);
    w10 = merge(32'h11223344, 32'hAABBCCDD, 4'b0101);
    xfer(0, "a_wr_be", 1'b0, 1'b1, 32'h00000010, 32'hAABBCCDD, 4'b0101, 2, 32'h0, 2'b00);
    xfer(0, "a_rd_be", 1'b1, 1'b0, 32'h00000010, 32'h0, 4'hF, 2, w10, 2'b00);
    check_eq("a_count3", 64'(xc_a), 64'd3);
    check_eq("a_err_clean", 64'(err_a), 64'h0);
    xfer(0, "a_wr_rom", 1'b0, 1'b1, 32'hBFC00004, 32'hFFFFFFFF, 4'hF, 2, 32'h0, 2'b10);
    check_eq("a_err_set", 64'(err_a), 64'h1);
    xfer(0, "a_rd_rom1", 1'b1, 1'b0, 32'hBFC00004, 32'h0, 4'hF, 2, 32'h0BADF00D, 2'b00);
    xfer(0, "a_rd_wr", 1'b1, 1'b1, 32'h00000010, 32'h01010101, 4'hF, 2, 32'h0, 2'b10);
    xfer(0, "a_rd_after", 1'b1, 1'b0, 32'h00000010, 32'h0, 4'hF, 2, w10, 2'b00);
    check_eq("a_count7", 64'(xc_a), 64'd7);

    // Reset while a write sits in WAIT
    @(posedge clk); #1;
    drive(0, 1'b0, 1'b1, 32'h00000014, 32'hFFFFFFFF, 4'hF);
    @(posedge clk); #1;
    rst_n = 1'b0;
    drive(0, 1'b0, 1'b0, 32'h00000014, 32'hFFFFFFFF, 4'hF);
    @(negedge clk);
    check_eq("mid_rst_rdata", 64'(bus_a.readdata), 64'h0);
    check_eq("mid_rst_err", 64'(err_a), 64'h0);
    check_eq("mid_rst_count", 64'(xc_a), 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    xfer(0, "a_rd_discard", 1'b1, 1'b0, 32'h00000014, 32'h0, 4'hF, 2, 32'h55667788, 2'b00);
    check_eq("a_count_post", 64'(xc_a), 64'd1);

    // Instance B: READ_DELAY=1, WRITE_DELAY=5
    xfer(1, "b_rd20", 1'b1, 1'b0, 32'h00000020, 32'h0, 4'hF, 1, 32'hCAFEF00D, 2'b00);
    xfer(1, "b_decerr", 1'b1, 1'b0, 32'h80000000, 32'h0, 4'hF, 1, 32'h0, 2'b11);
    check_eq("b_err_set", 64'(err_b), 64'h1);
    w20 = 32'h12345678;
    xfer(1, "b_wr5", 1'b0, 1'b1, 32'h00000020, w20, 4'hF, 5, 32'h0, 2'b00);
    xfer(1, "b_rd20b", 1'b1, 1'b0, 32'h00000020, 32'h0, 4'hF, 1, w20, 2'b00);

    // Master abandons a write after one WAIT cycle
    @(posedge clk); #1;
    drive(1, 1'b0, 1'b1, 32'h00000024, 32'h00000000, 4'hF);
    @(posedge clk); #1;
    @(posedge clk); #1;
    drive(1, 1'b0, 1'b0, 32'h00000024, 32'h00000000, 4'hF);
    @(posedge clk);
    @(negedge clk);
    check_eq("b_drop_count", 64'(xc_b), 64'd4);
    check_eq("b_drop_wait", 64'(bus_b.waitrequest), 64'h0);
    xfer(1, "b_rd_drop", 1'b1, 1'b0, 32'h00000024, 32'h0, 4'hF, 1, 32'hDEADBEEF, 2'b00);

    xfer(1, "b_wr_be0", 1'b0, 1'b1, 32'h00000020, 32'hFFFFFFFF, 4'h0, 5, 32'h0, 2'b00);
    xfer(1, "b_rd_be0", 1'b1, 1'b0, 32'h00000020, 32'h0, 4'hF, 1, merge(w20, 32'hFFFFFFFF, 4'h0), 2'b00);
    check_eq("b_count7", 64'(xc_b), 64'd7);
    check_eq("sb_empty", 64'(sb.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
